// File: rtl/uart_tx_frame.sv
// UART transmitter: internal baud divider, transmit FIFO, configurable data/parity/stop bits.
// Line outputs are registered from FSM state, so the line trails the state by one clock.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW    = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_bit, par_bit_d;
  logic                 tx_d, busy_d;
  logic                 fin, fin_d;
  logic                 pop, push, bit_end;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;

  assign tx_ready = (fifo_level != LW'(DEPTH)) && !rst;
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr];
  assign bit_end  = (cnt == CW'(CLK_DIV - 1));

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // State and line registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      fin     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      par_bit <= par_bit_d;
      fin     <= fin_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= fin;
    end
  end

  // Next state, bit sequencing and FIFO pop
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_bit_d = par_bit;
    fin_d     = 1'b0;
    pop       = 1'b0;
    tx_d      = 1'b1;
    busy_d    = (state != S_IDLE);

    if (state != S_IDLE) cnt_d = bit_end ? '0 : cnt + 1'b1;

    unique case (state)
      S_IDLE: begin
        if (fifo_level != '0) pop = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift[0];
        if (bit_end) begin
          shift_d = shift >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      S_PAR: begin
        tx_d = par_bit;
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            fin_d = 1'b1;
            if (fifo_level != '0) pop = 1'b1;
            else                  state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop always launches a fresh frame from the head word
    if (pop) begin
      shift_d   = head;
      par_bit_d = (PARITY == 1) ? ~^head : ^head;
      cnt_d     = '0;
      state_d   = S_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets, directed frame table, FIFO fill,
// mid-frame reset and randomized streaming checked against a frame-building model.
module tb_uart_tx_frame;

  logic             clk = 1'b0;
  logic [3:0]       rst_r = 4'hF;
  logic [3:0]       valid_r = 4'h0;
  logic [3:0][8:0]  data_r = '0;
  logic [3:0]       ready_w, tx_w, busy_w, done_w;
  logic [3:0][3:0]  lvl_w;

  int errors = 0;
  int checks = 0;
  int acc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] rw;

  int db_of[4]  = '{8, 8, 7, 9};
  int par_of[4] = '{0, 1, 2, 2};
  int sb_of[4]  = '{1, 1, 2, 2};
  int cd_of[4]  = '{4, 4, 4, 2};

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(4), .FIFO_AW(3)) u0 (
    .clk(clk), .rst(rst_r[0]), .tx_data(data_r[0][7:0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]),
    .fifo_level(lvl_w[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(4), .FIFO_AW(3)) u1 (
    .clk(clk), .rst(rst_r[1]), .tx_data(data_r[1][7:0]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]),
    .fifo_level(lvl_w[1]));
  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLK_DIV(4), .FIFO_AW(3)) u2 (
    .clk(clk), .rst(rst_r[2]), .tx_data(data_r[2][6:0]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]),
    .fifo_level(lvl_w[2]));
  uart_tx_frame #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(2), .CLK_DIV(2), .FIFO_AW(3)) u3 (
    .clk(clk), .rst(rst_r[3]), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]),
    .fifo_level(lvl_w[3]));

  typedef struct {
    int         sel;
    logic [8:0] word;
    logic [15:0] seq;   // line bit i of the frame at seq[i], start bit first
    int         nbits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the line should carry it: start, data LSB first, optional parity, stop bits
  function automatic void build(input logic [8:0] w, input int db, input int par, input int sb,
                                output logic [15:0] bits, output int nb);
    int ones;
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < db; i++) begin
      bits[nb] = w[i];
      ones += int'(w[i]);
      nb++;
    end
    if (par != 0) begin
      bits[nb] = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      nb++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
  endfunction

  task automatic push(input int s, input logic [8:0] w);
    int n;
    n = 0;
    @(negedge clk);
    data_r[s]  = w;
    valid_r[s] = 1'b1;
    while (!ready_w[s] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_w[s]) begin
      chk("push_ready", 32'(ready_w[s]), 1);
      valid_r[s] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid_r[s] = 1'b0;
  endtask

  task automatic wait_start(input int s, output bit ok);
    int w;
    w = 0;
    while (tx_w[s] !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    ok = (tx_w[s] === 1'b0);
    if (!ok) chk("start_seen", 32'(tx_w[s]), 0);
  endtask

  // Follows n frames cycle by cycle from the first start bit; strict demands no idle gap
  task automatic run_stream(input int s, input int n, input bit strict,
                            input bit use_ovr, input logic [15:0] ovr, input int ovr_nb);
    logic [15:0] bits;
    int nb, cd;
    bit ok;
    logic [8:0] word;
    cd = cd_of[s];
    wait_start(s, ok);
    if (!ok) return;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk("queue_depth", 32'(exp_q.size()), 1);
        return;
      end
      word = exp_q.pop_front();
      build(word, db_of[s], par_of[s], sb_of[s], bits, nb);
      if (use_ovr) begin
        bits = ovr;
        nb   = ovr_nb;
      end
      for (int t = 0; t < nb * cd; t++) begin
        if (t > 0) @(negedge clk);
        chk("tx_bit", 32'(tx_w[s]), 32'(bits[t / cd]));
        chk("busy", 32'(busy_w[s]), 1);
        if (t > 0) chk("done_early", 32'(done_w[s]), 0);
      end
      @(negedge clk);
      chk("done", 32'(done_w[s]), 1);
      if (k < n - 1) begin
        if (strict) chk("no_gap", 32'(tx_w[s]), 0);
        wait_start(s, ok);
        if (!ok) return;
      end else begin
        chk("idle_tx", 32'(tx_w[s]), 1);
        chk("idle_busy", 32'(busy_w[s]), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_w[s]), 0);
      end
    end
  endtask

  vec_t vecs[5];
  int   bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 0, word: 9'h055, seq: 16'h02AA, nbits: 10};
    vecs[1] = '{sel: 1, word: 9'h0A3, seq: 16'h0746, nbits: 11};
    vecs[2] = '{sel: 2, word: 9'h041, seq: 16'h0682, nbits: 11};
    vecs[3] = '{sel: 0, word: 9'h0FF, seq: 16'h03FE, nbits: 10};
    vecs[4] = '{sel: 2, word: 9'h07F, seq: 16'h07FE, nbits: 11};

    // Reset values
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("rst_tx", 32'(tx_w[s]), 1);
      chk("rst_busy", 32'(busy_w[s]), 0);
      chk("rst_done", 32'(done_w[s]), 0);
      chk("rst_ready", 32'(ready_w[s]), 0);
      chk("rst_level", 32'(lvl_w[s]), 0);
    end
    rst_r = 4'h0;
    #1;
    for (int s = 0; s < 4; s++) chk("ready_after_rst", 32'(ready_w[s]), 1);

    // Directed single frames, including handshake-to-start latency
    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      exp_q.push_back(vecs[v].word);
      push(vecs[v].sel, vecs[v].word);
      @(negedge clk);
      chk("lat_e0_tx", 32'(tx_w[vecs[v].sel]), 1);
      chk("lat_e0_level", 32'(lvl_w[vecs[v].sel]), 1);
      @(negedge clk);
      chk("lat_e1_tx", 32'(tx_w[vecs[v].sel]), 1);
      @(negedge clk);
      chk("lat_e2_tx", 32'(tx_w[vecs[v].sel]), 0);
      chk("lat_e2_level", 32'(lvl_w[vecs[v].sel]), 0);
      run_stream(vecs[v].sel, 1, 1'b0, 1'b1, vecs[v].seq, vecs[v].nbits);
    end

    // FIFO fill: valid held 10 cycles, 9 words accepted and sent back-to-back
    exp_q.delete();
    acc = 0;
    fork
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          data_r[0]  = 9'(32'h30 + acc);
          valid_r[0] = 1'b1;
          if (ready_w[0]) begin
            exp_q.push_back(data_r[0]);
            acc++;
          end
        end
        @(negedge clk);
        valid_r[0] = 1'b0;
        chk("fill_level", 32'(lvl_w[0]), 8);
        chk("fill_ready", 32'(ready_w[0]), 0);
        chk("fill_accepted", 32'(acc), 9);
      end
      run_stream(0, 9, 1'b1, 1'b0, '0, 0);
    join
    chk("fill_drained", 32'(lvl_w[0]), 0);

    // Reset during data bit 3 of the first of two queued frames
    exp_q.delete();
    push(0, 9'h0C3);
    push(0, 9'h03C);
    begin
      bit ok;
      wait_start(0, ok);
    end
    repeat (17) @(negedge clk);
    rst_r[0] = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx_w[0]), 1);
    chk("abort_level", 32'(lvl_w[0]), 0);
    chk("abort_busy", 32'(busy_w[0]), 0);
    chk("abort_done", 32'(done_w[0]), 0);
    chk("abort_ready", 32'(ready_w[0]), 0);
    rst_r[0] = 1'b0;
    #1 chk("release_ready", 32'(ready_w[0]), 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    chk("post_abort_quiet", 32'(bad), 0);
    chk("post_abort_level", 32'(lvl_w[0]), 0);
    exp_q.push_back(9'h0A5);
    push(0, 9'h0A5);
    run_stream(0, 1, 1'b0, 1'b0, '0, 0);

    // Randomized streaming at CLK_DIV=2, 9E2 framing
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 30)) @(negedge clk);
          rw = 9'($urandom);
          exp_q.push_back(rw);
          push(3, rw);
        end
      end
      run_stream(3, 16, 1'b0, 1'b0, '0, 0);
    join
    chk("stream_level", 32'(lvl_w[3]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
